prco_lmem_arb: RTL and testbench
================================

Name: prco_lmem_arb

Overview:
- Parametrised successor to the core's single-port local memory.
- One synchronous storage array of DEPTH words x DATA_W bits, shared by two requesters: port A (CPU core) and port B (loader/DMA).
- A per-cycle arbiter grants at most one access per clock. Data returns on a registered path in write-first style.
- Sits between the core/loader and on-chip RAM. Replaces the hard-wired 16-bit single-requester memory.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 32, number of words; must be a power of two, >= 2.
- ADDR_W, 16, address port width; only the low log2(DEPTH) bits index the array.
- RR_EN, 1, arbitration mode: 1 = round-robin on conflict, 0 = fixed priority to port A.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_a_req  in  1  port A access request; held until granted.
- i_a_we  in  1  port A write enable (1 = write, 0 = read).
- i_a_addr  in  ADDR_W  port A word address.
- i_a_din  in  DATA_W  port A write data.
- q_a_gnt  out  1  port A grant, combinational, same cycle as the request.
- q_a_dout  out  DATA_W  port A registered read/write-back data.
- q_a_valid  out  1  one-cycle pulse: q_a_dout is updated.
- i_b_req, i_b_we, i_b_addr, i_b_din, q_b_gnt, q_b_dout, q_b_valid: same as port A, for port B.
- q_err  out  1  one-cycle pulse on an out-of-range access (see Optional Feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, any time):
  - q_a_dout, q_b_dout = 0; q_a_valid, q_b_valid, q_err = 0.
  - Round-robin pointer = "last granted B", so A wins the first tie.
  - Array contents are not reset.
  - No access is performed in any cycle where i_rst is high; an access in progress is dropped, not replayed.
- Arbitration (combinational, per cycle; never more than one grant):
  - Only A requests -> q_a_gnt = 1.
  - Only B requests -> q_b_gnt = 1.
  - Both request, RR_EN = 1 -> grant the port not granted most recently.
  - Both request, RR_EN = 0 -> A always wins.
  - Neither requests -> no grant; round-robin pointer unchanged.
  - Pointer updates at the clock edge only when a grant occurs.
- Access (performed at the rising edge where req && gnt):
  - Write: mem[addr mod DEPTH] <= din. The granted port's dout <= din (write-first) and its valid = 1 for one cycle.
  - Read: the granted port's dout <= mem[addr mod DEPTH]; valid = 1 for one cycle.
  - Latency: data and valid are visible immediately after the granting edge (1 cycle).
- The non-granted port's dout holds its last value and its valid = 0.
- Back-to-back accesses from the same port are allowed every cycle.
- A write from one port followed next cycle by a read of the same address from the other port returns the new data.
- Requester obligation: hold req/we/addr/din stable until gnt is seen high. Dropping req before grant is legal and cancels the access.
- Address wrap (feature compiled out): addr >= DEPTH aliases to addr mod DEPTH, e.g. DEPTH = 32, addr 33 -> word 1.

Optional Feature:
- Macro: PRCO_LMEM_BOUNDS_EN.
- Defined:
  - A granted access with addr >= DEPTH performs no write.
  - The granted port's dout <= 0 and its valid pulses as normal.
  - q_err pulses for one cycle.
  - The grant and round-robin pointer still update, so the bad request is consumed and cannot deadlock the port.
- Not defined: address wraps modulo DEPTH; q_err is constant 0.

Test Plan:
- Reset: assert i_rst mid-cycle with A granted -> all q_* = 0 immediately (asynchronous); no write occurs at the next edge.
- Single-port write/read: A writes 16'hab to addr 0, then 16'hcd to addr 1 -> q_a_dout = 16'hab, then 16'hcd, each with a valid pulse. Then A reads addr 0 -> q_a_dout = 16'hab.
- Conflict, RR_EN = 1: A and B both request for 4 cycles -> grants alternate A, B, A, B. Each dout/valid appears only on its own port.
- Conflict, RR_EN = 0: both request for 3 cycles -> A granted every cycle; q_b_gnt = 0 and q_b_dout unchanged.
- Cross-port coherency: B writes 16'h1234 to addr 5, then A reads addr 5 the next cycle -> q_a_dout = 16'h1234.
- Out-of-range access, DEPTH = 32, addr 33:
  - Without PRCO_LMEM_BOUNDS_EN: a write of 16'h77 lands in word 1.
  - With PRCO_LMEM_BOUNDS_EN: word 1 is unchanged, q_err pulses once, q_a_dout = 0.

Source files
------------

// File: rtl/prco_lmem_arb.sv
// Two-requester local memory: one synchronous array, per-cycle arbiter, write-first registered data.
// Optional PRCO_LMEM_BOUNDS_EN rejects addresses >= DEPTH instead of wrapping them.
module prco_lmem_arb #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 16,
    parameter int RR_EN  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_din,
    output logic              q_a_gnt,
    output logic [DATA_W-1:0] q_a_dout,
    output logic              q_a_valid,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_din,
    output logic              q_b_gnt,
    output logic [DATA_W-1:0] q_b_dout,
    output logic              q_b_valid,
    output logic              q_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              last_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              acc;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic [AW-1:0]     idx;
    logic              oob;
    logic              wr;
    logic [DATA_W-1:0] rdata;

    // Grants are suppressed while reset is held so no access can slip through.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!i_rst) begin
            if (i_a_req && i_b_req) begin
                if ((RR_EN == 0) || last_b)
                    gnt_a = 1'b1;
                else
                    gnt_b = 1'b1;
            end else begin
                gnt_a = i_a_req;
                gnt_b = i_b_req;
            end
        end
    end

    assign acc      = gnt_a | gnt_b;
    assign sel_we   = gnt_b ? i_b_we   : i_a_we;
    assign sel_addr = gnt_b ? i_b_addr : i_a_addr;
    assign sel_din  = gnt_b ? i_b_din  : i_a_din;
    assign idx      = sel_addr[AW-1:0];

`ifdef PRCO_LMEM_BOUNDS_EN
    assign oob = (sel_addr >= ADDR_W'(DEPTH));
`else
    // Upper address bits are ignored so accesses alias modulo DEPTH.
    assign oob = 1'b0 & (|sel_addr);
`endif

    assign wr = acc & sel_we & ~oob;

    always_comb begin
        rdata = '0;
        if (!oob)
            rdata = sel_we ? sel_din : mem[idx];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && wr)
            mem[idx] <= sel_din;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_a_dout  <= '0;
            q_b_dout  <= '0;
            q_a_valid <= 1'b0;
            q_b_valid <= 1'b0;
            q_err     <= 1'b0;
            last_b    <= 1'b1;
        end else begin
            q_a_valid <= gnt_a;
            q_b_valid <= gnt_b;
            q_err     <= acc & oob;
            if (gnt_a)
                q_a_dout <= rdata;
            if (gnt_b)
                q_b_dout <= rdata;
            if (acc)
                last_b <= gnt_b;
        end
    end

    assign q_a_gnt = gnt_a;
    assign q_b_gnt = gnt_b;

endmodule

// File: tb/tb_prco_lmem_arb.sv
// Directed bench for prco_lmem_arb: a round-robin instance and a fixed-priority
// instance share stimulus; expected values are hand-computed.
module tb_prco_lmem_arb;

    localparam int DW = 16;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    logic          a_gnt, a_valid, b_gnt, b_valid, err;
    logic [DW-1:0] a_dout, b_dout;
    logic          fa_gnt, fa_valid, fb_gnt, fb_valid, ferr;
    logic [DW-1:0] fa_dout, fb_dout;

    int n_chk;
    int n_err;

    prco_lmem_arb #(.DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .RR_EN(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_din(a_din),
        .q_a_gnt(a_gnt), .q_a_dout(a_dout), .q_a_valid(a_valid),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_din(b_din),
        .q_b_gnt(b_gnt), .q_b_dout(b_dout), .q_b_valid(b_valid),
        .q_err(err)
    );

    prco_lmem_arb #(.DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .RR_EN(0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_din(a_din),
        .q_a_gnt(fa_gnt), .q_a_dout(fa_dout), .q_a_valid(fa_valid),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_din(b_din),
        .q_b_gnt(fb_gnt), .q_b_dout(fb_dout), .q_b_valid(fb_valid),
        .q_err(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        a_req = req; a_we = we; a_addr = addr; a_din = din;
    endtask

    task automatic drive_b(input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        b_req = req; b_we = we; b_addr = addr; b_din = din;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        step();
        step();
        chk("rst_a_dout", 32'(a_dout), 32'h0);
        chk("rst_b_dout", 32'(b_dout), 32'h0);
        chk("rst_valid", {a_valid, b_valid, err}, 32'h0);
        rst = 1'b0;
        step();

        // single-port write/read on A
        drive_a(1'b1, 1'b1, 16'd0, 16'hab);
        #1 chk("wr0_gnt", {a_gnt, b_gnt}, 32'b10);
        step();
        chk("wr0_dout", 32'(a_dout), 32'hab);
        chk("wr0_valid", {a_valid, b_valid}, 32'b10);
        drive_a(1'b1, 1'b1, 16'd1, 16'hcd);
        step();
        chk("wr1_dout", 32'(a_dout), 32'hcd);
        chk("wr1_valid", 32'(a_valid), 32'h1);
        drive_a(1'b1, 1'b0, 16'd0, 16'h0);
        step();
        chk("rd0_dout", 32'(a_dout), 32'hab);
        drive_a(1'b0, 1'b0, 16'd0, 16'h0);
        step();
        chk("idle_valid", {a_valid, b_valid}, 32'b00);
        chk("idle_hold", 32'(a_dout), 32'hab);

        // cross-port coherency
        drive_b(1'b1, 1'b1, 16'd5, 16'h1234);
        #1 chk("bwr_gnt", {a_gnt, b_gnt}, 32'b01);
        step();
        chk("bwr_dout", 32'(b_dout), 32'h1234);
        chk("bwr_valid", {a_valid, b_valid}, 32'b01);
        drive_b(1'b0, 1'b0, 16'd0, 16'h0);
        drive_a(1'b1, 1'b0, 16'd5, 16'h0);
        step();
        chk("coh_a_dout", 32'(a_dout), 32'h1234);
        chk("coh_b_hold", 32'(b_dout), 32'h1234);

        // leave B as last granted so A wins the first tie
        drive_a(1'b0, 1'b0, 16'd0, 16'h0);
        drive_b(1'b1, 1'b0, 16'd5, 16'h0);
        step();
        chk("brd_dout", 32'(b_dout), 32'h1234);

        // conflict: A reads word 0 (ab), B reads word 1 (cd)
        drive_a(1'b1, 1'b0, 16'd0, 16'h0);
        drive_b(1'b1, 1'b0, 16'd1, 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), {a_gnt, b_gnt},
                (k % 2 == 0) ? 32'b10 : 32'b01);
            chk($sformatf("fp_gnt%0d", k), {fa_gnt, fb_gnt}, 32'b10);
            step();
            chk($sformatf("rr_valid%0d", k), {a_valid, b_valid},
                (k % 2 == 0) ? 32'b10 : 32'b01);
            chk($sformatf("fp_valid%0d", k), {fa_valid, fb_valid}, 32'b10);
            chk($sformatf("fp_b_hold%0d", k), 32'(fb_dout), 32'h1234);
        end
        chk("rr_a_dout", 32'(a_dout), 32'hab);
        chk("rr_b_dout", 32'(b_dout), 32'hcd);
        chk("fp_a_dout", 32'(fa_dout), 32'hab);
        drive_b(1'b0, 1'b0, 16'd0, 16'h0);

        // out-of-range access at addr 33
        drive_a(1'b1, 1'b1, 16'd33, 16'h77);
        #1 chk("oob_gnt", 32'(a_gnt), 32'h1);
        step();
`ifdef PRCO_LMEM_BOUNDS_EN
        chk("oob_dout", 32'(a_dout), 32'h0);
        chk("oob_err", 32'(err), 32'h1);
`else
        chk("oob_dout", 32'(a_dout), 32'h77);
        chk("oob_err", 32'(err), 32'h0);
`endif
        chk("oob_valid", 32'(a_valid), 32'h1);
        drive_a(1'b1, 1'b0, 16'd1, 16'h0);
        step();
        chk("err_pulse", 32'(err), 32'h0);
`ifdef PRCO_LMEM_BOUNDS_EN
        chk("w1_after_oob", 32'(a_dout), 32'hcd);
`else
        chk("w1_after_oob", 32'(a_dout), 32'h77);
`endif

        // async reset mid-cycle while A holds a granted write
        drive_a(1'b1, 1'b1, 16'd0, 16'h99);
        #1 chk("prerst_gnt", 32'(a_gnt), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_a_dout", 32'(a_dout), 32'h0);
        chk("arst_flags", {a_valid, b_valid, err, a_gnt, b_gnt}, 32'h0);
        step();
        chk("rst_edge_valid", 32'(a_valid), 32'h0);
        drive_a(1'b0, 1'b0, 16'd0, 16'h0);
        rst = 1'b0;
        step();
        drive_a(1'b1, 1'b0, 16'd0, 16'h0);
        step();
        chk("no_wr_in_rst", 32'(a_dout), 32'hab);
        drive_a(1'b0, 1'b0, 16'd0, 16'h0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
